serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing d = a − b − b_in one bit per clock, LSB first, through a single borrow flip-flop. It is the subtraction-side companion to the team's parallel full-adder/ripple-carry datapath. It trades latency for area: one full-subtractor cell plus shift registers instead of N cells. A start/busy/done handshake lets a controller issue operations and collect results.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             ovf;

  modport master (
    output start, a, b, b_in,
    input  busy, done, d, b_out, ovf
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, d, b_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock LSB first,
// through a single borrow flip-flop, with start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_ai;
  logic             w_bi;
  logic             w_diff;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_accept     = bus.start && (r_state != S_SHIFT);
  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  assign w_ai         = r_a[0];
  assign w_bi         = r_b[0];
  assign w_diff       = w_ai ^ w_bi ^ r_borrow;
  assign w_borrow_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_res_nxt    = {w_diff, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_borrow <= bus.b_in;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_res    <= w_res_nxt;
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_borrow <= w_borrow_nxt;
      r_cnt    <= r_cnt + 1'b1;
      // Results publish only at the MSB step, so d never shows partial shifts.
      if (w_last) begin
        r_d    <= w_res_nxt;
        r_bout <= w_borrow_nxt;
        r_ovf  <= r_borrow ^ w_borrow_nxt;
      end
    end
  end

  assign bus.busy  = (r_state == S_SHIFT);
  assign bus.done  = (r_state == S_DONE);
  assign bus.d     = r_d;
  assign bus.b_out = r_bout;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, random ops
// against an arithmetic model, back-to-back issue and mid-operation reset.
module tb_serial_subtractor;
  localparam int unsigned W = 4;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_prev_d = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int bin;
    int d;
    int bout;
    int ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int a, input int b, input int bin,
                                output int d, output int bout, output int ovf);
    int diff;
    int sa;
    int sb;
    int sd;
    diff = a - b - bin;
    d    = ((diff % MOD) + MOD) % MOD;
    bout = (diff < 0) ? 1 : 0;
    sa   = (a >= HALF) ? a - MOD : a;
    sb   = (b >= HALF) ? b - MOD : b;
    sd   = sa - sb - bin;
    ovf  = (sd < -HALF || sd > HALF - 1) ? 1 : 0;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
  task automatic run_op(input int a, input int b, input int bin,
                        input int ed, input int eb, input int eo);
    int cyc;
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.b_in  = bin[0];
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.b_in  = 1'($urandom);
    check("busy_after_accept", int'(bus.busy), 1);
    check("d_held_in_shift", int'(bus.d), exp_prev_d);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, W);
    check("d", int'(bus.d), ed);
    check("b_out", int'(bus.b_out), eb);
    check("ovf", int'(bus.ovf), eo);
    check("busy_at_done", int'(bus.busy), 0);
    exp_prev_d = ed;
    @(negedge clk);
    check("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    int ed, eb, eo;
    int ops_a[16];
    int ops_b[16];
    int ops_c[16];
    int acc;

    vecs[0] = '{a: 7,  b: 3,  bin: 0, d: 4,   bout: 0, ovf: 0};
    vecs[1] = '{a: 3,  b: 7,  bin: 0, d: 12,  bout: 1, ovf: 0};
    vecs[2] = '{a: 8,  b: 1,  bin: 0, d: 7,   bout: 0, ovf: 1};
    vecs[3] = '{a: 7,  b: 15, bin: 0, d: 8,   bout: 1, ovf: 1};
    vecs[4] = '{a: 0,  b: 0,  bin: 1, d: 15,  bout: 1, ovf: 0};
    vecs[5] = '{a: 15, b: 15, bin: 1, d: 15,  bout: 1, ovf: 0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_d", int'(bus.d), 0);
    check("rst_b_out", int'(bus.b_out), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_prev_d = 0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].ovf);
    end

    for (int i = 0; i < 30; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(MOD - 1, 0));
      rb = int'($urandom_range(MOD - 1, 0));
      rc = int'($urandom_range(1, 0));
      model(ra, rb, rc, ed, eb, eo);
      run_op(ra, rb, rc, ed, eb, eo);
    end

    // start held high for 12 cycles; only the ops at E0, E5, E10 are taken
    for (int k = 0; k < 16; k++) begin
      check("b2b_done", int'(bus.done), (k == 5 || k == 10 || k == 15) ? 1 : 0);
      check("b2b_busy", int'(bus.busy), (k != 0 && k != 5 && k != 10 && k != 15) ? 1 : 0);
      if (k == 5 || k == 10 || k == 15) begin
        acc = k - 5;
        model(ops_a[acc], ops_b[acc], ops_c[acc], ed, eb, eo);
        check("b2b_d", int'(bus.d), ed);
        check("b2b_b_out", int'(bus.b_out), eb);
        check("b2b_ovf", int'(bus.ovf), eo);
        exp_prev_d = ed;
      end
      ops_a[k] = int'($urandom_range(MOD - 1, 0));
      ops_b[k] = int'($urandom_range(MOD - 1, 0));
      ops_c[k] = int'($urandom_range(1, 0));
      bus.start = (k < 12);
      bus.a     = W'(ops_a[k]);
      bus.b     = W'(ops_b[k]);
      bus.b_in  = ops_c[k][0];
      @(negedge clk);
    end
    check("b2b_idle", int'(bus.done), 0);

    // Mid-operation asynchronous reset discards the partial result
    run_op(7, 3, 0, 4, 0, 0);
    bus.start = 1'b1;
    bus.a     = W'(9);
    bus.b     = W'(2);
    bus.b_in  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_d", int'(bus.d), 0);
    check("mid_rst_b_out", int'(bus.b_out), 0);
    check("mid_rst_ovf", int'(bus.ovf), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("held_rst_done", int'(bus.done), 0);
    end
    rst = 1'b0;
    exp_prev_d = 0;
    run_op(5, 5, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
